// File: rtl/eth_pkg.sv
// Shared types and widths for the Ethernet transmit path.
package eth_pkg;
  localparam int ETH_LEN_W  = 11;
  localparam int ETH_ADDR_W = 11;
  localparam int ETH_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    SEND,
    GAP
  } tx_state_e;
endpackage

// File: rtl/eth_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a single MAC transmitter.
// It owns the MAC for one frame at a time and enforces an inter-frame gap.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int GAP_CYCLES    = 24,
  parameter int START_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r1_req,
  input  logic [ETH_LEN_W-1:0]  r0_count,
  input  logic [ETH_LEN_W-1:0]  r1_count,
  input  logic [ETH_DATA_W-1:0] r0_data,
  input  logic [ETH_DATA_W-1:0] r1_data,
  output logic                  r0_gnt,
  output logic                  r1_gnt,
  output logic                  r0_done,
  output logic                  r1_done,
  output logic                  r0_adv,
  output logic                  r1_adv,
  output logic [ETH_ADDR_W-1:0] tx_addr,
  output logic                  m_tx_vld,
  output logic [ETH_LEN_W-1:0]  m_tx_count,
  output logic [ETH_DATA_W-1:0] m_tx_data,
  input  logic                  m_tx_busy,
  input  logic                  m_tx_adv,
  input  logic                  m_tx_last,
  input  logic [ETH_ADDR_W-1:0] m_tx_addr,
  output logic                  timeout_err
);

  localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TMO_W   = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;
  localparam int GAP_END = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int TMO_END = (START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0;

  localparam logic [GAP_W-1:0] GAP_END_V = GAP_END[GAP_W-1:0];
  localparam logic [TMO_W-1:0] TMO_END_V = TMO_END[TMO_W-1:0];
  localparam logic [TMO_W-1:0] TMO_MAX   = '1;

  tx_state_e            state, state_nxt;
  logic                 owner;      // 0 = r0, 1 = r1
  logic                 last_srv;   // requester served most recently
  logic [ETH_LEN_W-1:0] count_q;
  logic [GAP_W-1:0]     gap_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [1:0]           done_q;
  logic                 tmo_err_q;

  logic take, pick_r1, fin, tmo_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Ties go to whoever was not served last; a lone requester always wins.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick_r1   = 1'b0;
    fin       = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        if ((r0_req || r1_req) && !m_tx_busy) begin
          take      = 1'b1;
          pick_r1   = r1_req && (!r0_req || !last_srv);
          state_nxt = START;
        end
      end
      START: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (m_tx_busy) begin
          state_nxt = SEND;
        end else if (tmo_cnt == TMO_END_V) begin
          tmo_hit   = 1'b1;
          fin       = 1'b1;
          state_nxt = GAP;
        end
      end
      SEND: begin
        if ((m_tx_adv && m_tx_last) || !m_tx_busy) begin
          fin       = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_END_V) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= 1'b0;
      last_srv  <= 1'b1;
      count_q   <= '0;
      gap_cnt   <= '0;
      tmo_cnt   <= '0;
      done_q    <= 2'b00;
      tmo_err_q <= 1'b0;
    end else begin
      done_q    <= fin ? (owner ? 2'b10 : 2'b01) : 2'b00;
      tmo_err_q <= tmo_hit;
      if (take) begin
        owner    <= pick_r1;
        last_srv <= pick_r1;
        count_q  <= pick_r1 ? r1_count : r0_count;
      end
      // Timeout counter saturates so a stuck MAC can never make it wrap.
      if (state == WAIT_BUSY) begin
        if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end
      if (state == GAP) gap_cnt <= gap_cnt + GAP_W'(1);
      else              gap_cnt <= '0;
    end
  end

  assign m_tx_vld    = (state == START);
  assign r0_gnt      = (state == START) && !owner;
  assign r1_gnt      = (state == START) &&  owner;
  assign m_tx_count  = count_q;
  assign m_tx_data   = owner ? r1_data : r0_data;
  assign tx_addr     = m_tx_addr;
  assign r0_adv      = m_tx_adv && (state == SEND) && !owner;
  assign r1_adv      = m_tx_adv && (state == SEND) &&  owner;
  assign r0_done     = done_q[0];
  assign r1_done     = done_q[1];
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter with a cycle-accurate MAC model.
module tb_eth_tx_arbiter;
  localparam int GAP = 6;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r1_req;
  logic [10:0] r0_count, r1_count;
  logic [7:0]  r0_data, r1_data;
  logic        r0_gnt, r1_gnt, r0_done, r1_done, r0_adv, r1_adv;
  logic [10:0] tx_addr, m_tx_count, m_tx_addr;
  logic [7:0]  m_tx_data;
  logic        m_tx_vld, m_tx_busy, m_tx_adv, m_tx_last, timeout_err;

  typedef struct {
    logic        id;
    logic [10:0] count;
  } frame_t;

  frame_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester buffers: r0 holds its address, r1 a scrambled copy.
  assign r0_data = tx_addr[7:0];
  assign r1_data = tx_addr[7:0] ^ 8'hA5;

  eth_tx_arbiter #(.GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r1_req(r1_req),
    .r0_count(r0_count), .r1_count(r1_count),
    .r0_data(r0_data), .r1_data(r1_data),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
    .r0_done(r0_done), .r1_done(r1_done),
    .r0_adv(r0_adv), .r1_adv(r1_adv),
    .tx_addr(tx_addr),
    .m_tx_vld(m_tx_vld), .m_tx_count(m_tx_count), .m_tx_data(m_tx_data),
    .m_tx_busy(m_tx_busy), .m_tx_adv(m_tx_adv), .m_tx_last(m_tx_last),
    .m_tx_addr(m_tx_addr),
    .timeout_err(timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // MAC model plus per-frame monitor; entered and left at posedge+1.
  task automatic serve(input bit no_busy, input int abort_byte, input int raise_byte,
                       input logic [1:0] raise_mask, input logic [1:0] drop_mask,
                       output int vld_cyc, output int done_cyc);
    frame_t f;
    int n;
    logic [7:0] d_exp;
    logic [3:0] st_exp;
    vld_cyc  = -1;
    done_cyc = -1;
    n = 0;
    forever begin
      #1;
      if (m_tx_vld === 1'b1 || n >= 100) break;
      step();
      n++;
    end
    n_checks++;
    if (m_tx_vld !== 1'b1 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL start: vld=%b pending=%0d after %0d cycles, expected vld=1", m_tx_vld, sb.size(), n);
      step();
      return;
    end
    f = sb.pop_front();
    vld_cyc = cyc;
    n_checks++;
    if ({r1_gnt, r0_gnt} !== (f.id ? 2'b10 : 2'b01) || m_tx_count !== f.count) begin
      n_fail++;
      $display("FAIL grant: gnt(r1,r0)=%b%b count=%0d, expected owner r%0d count=%0d",
               r1_gnt, r0_gnt, m_tx_count, f.id, f.count);
    end
    r0_req = r0_req & ~drop_mask[0];
    r1_req = r1_req & ~drop_mask[1];
    step();
    if (no_busy) begin
      n = 0;
      forever begin
        #1;
        if (timeout_err === 1'b1 || n >= TMO + 10) break;
        step();
        n++;
      end
      n_checks++;
      if (timeout_err !== 1'b1 || cyc - vld_cyc != TMO + 1 ||
          {r1_done, r0_done} !== (f.id ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL timeout: err=%b done(r1,r0)=%b%b at +%0d, expected err=1 and r%0d done at +%0d",
                 timeout_err, r1_done, r0_done, cyc - vld_cyc, f.id, TMO + 1);
      end
      done_cyc = cyc;
      step();
      return;
    end
    step();
    m_tx_busy = 1'b1;
    step();
    for (int i = 0; i < int'(f.count); i++) begin
      m_tx_adv  = 1'b1;
      m_tx_addr = 11'(i);
      m_tx_last = (i == int'(f.count) - 1);
      if (i == raise_byte) begin
        r0_req = r0_req | raise_mask[0];
        r1_req = r1_req | raise_mask[1];
      end
      if (i == abort_byte) begin
        reset = 1'b1;
        #1;
        n_checks++;
        if ({r0_gnt, r1_gnt, r0_done, r1_done, r0_adv, r1_adv, m_tx_vld, timeout_err} !== 8'h00 ||
            m_tx_count !== 11'd0) begin
          n_fail++;
          $display("FAIL reset_abort: pulses=%b count=%0d, expected all zero",
                   {r0_gnt, r1_gnt, r0_done, r1_done, r0_adv, r1_adv, m_tx_vld, timeout_err}, m_tx_count);
        end
        m_tx_adv  = 1'b0;
        m_tx_last = 1'b0;
        m_tx_busy = 1'b0;
        m_tx_addr = '0;
        for (int k = 0; k < 6; k++) begin
          step();
          if (k == 2) reset = 1'b0;
          #1;
          n_checks++;
          if ({r0_done, r1_done, timeout_err, m_tx_vld} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_quiet: done(r0,r1)=%b%b err=%b vld=%b, expected 0000",
                     r0_done, r1_done, timeout_err, m_tx_vld);
          end
        end
        step();
        return;
      end
      #1;
      d_exp  = f.id ? (8'(i) ^ 8'hA5) : 8'(i);
      st_exp = f.id ? 4'b0010 : 4'b0001;
      n_checks++;
      if ({r1_done, r0_done, r1_adv, r0_adv} !== st_exp || m_tx_data !== d_exp || tx_addr !== 11'(i)) begin
        n_fail++;
        $display("FAIL byte %0d: done/adv=%b data=%h addr=%0d, expected %b %h %0d",
                 i, {r1_done, r0_done, r1_adv, r0_adv}, m_tx_data, tx_addr, st_exp, d_exp, i);
      end
      step();
    end
    m_tx_adv  = 1'b0;
    m_tx_last = 1'b0;
    m_tx_busy = 1'b0;
    #1;
    n_checks++;
    if ({r1_done, r0_done, r1_adv, r0_adv} !== (f.id ? 4'b1000 : 4'b0100)) begin
      n_fail++;
      $display("FAIL done: done/adv=%b, expected done for r%0d only", {r1_done, r0_done, r1_adv, r0_adv}, f.id);
    end
    done_cyc = cyc;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    r0_req = 1'b1;
    r0_count = 11'd9;
    repeat (3) step();
    #1;
    n_checks++;
    if ({r0_gnt, r1_gnt, r0_done, r1_done, r0_adv, r1_adv, m_tx_vld, timeout_err} !== 8'h00 ||
        m_tx_count !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_hold: pulses=%b count=%0d, expected all zero",
               {r0_gnt, r1_gnt, r0_done, r1_done, r0_adv, r1_adv, m_tx_vld, timeout_err}, m_tx_count);
    end
    r0_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    #1;
    n_checks++;
    if ({r0_gnt, r1_gnt, m_tx_vld, timeout_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: gnt/vld/err=%b, expected 0000", {r0_gnt, r1_gnt, m_tx_vld, timeout_err});
    end
    step();
  endtask

  task automatic test_both();
    int v0, d0, v1, d1;
    r0_count = 11'd8;
    r1_count = 11'd5;
    r0_req = 1'b1;
    r1_req = 1'b1;
    sb.push_back('{1'b0, 11'd8});
    sb.push_back('{1'b1, 11'd5});
    serve(0, -1, -1, 2'b00, 2'b01, v0, d0);
    serve(0, -1, -1, 2'b00, 2'b10, v1, d1);
    n_checks++;
    if (v1 - d0 != GAP + 1) begin
      n_fail++;
      $display("FAIL both_gap: r1 gnt %0d cycles after r0 done, expected %0d", v1 - d0, GAP + 1);
    end
  endtask

  task automatic test_single();
    int v, d;
    r0_count = 11'd60;
    r0_req = 1'b1;
    sb.push_back('{1'b0, 11'd60});
    serve(0, -1, -1, 2'b00, 2'b01, v, d);
  endtask

  task automatic test_timeout();
    int v, d, v2, d2;
    r1_count = 11'd0;
    r1_req = 1'b1;
    sb.push_back('{1'b1, 11'd0});
    serve(1, -1, -1, 2'b00, 2'b10, v, d);
    r0_count = 11'd3;
    r0_req = 1'b1;
    sb.push_back('{1'b0, 11'd3});
    serve(0, -1, -1, 2'b00, 2'b01, v2, d2);
    n_checks++;
    if (v2 - d != GAP + 1) begin
      n_fail++;
      $display("FAIL timeout_gap: next gnt %0d cycles after timeout, expected %0d", v2 - d, GAP + 1);
    end
  endtask

  task automatic test_alternate();
    int v, d, nv;
    r0_count = 11'd7;
    r1_count = 11'd10;
    r1_req = 1'b1;
    sb.push_back('{1'b1, 11'd10});
    sb.push_back('{1'b0, 11'd7});
    sb.push_back('{1'b1, 11'd10});
    sb.push_back('{1'b0, 11'd7});
    serve(0, -1, 3, 2'b01, 2'b00, v, d);
    serve(0, -1, -1, 2'b00, 2'b00, v, d);
    serve(0, -1, -1, 2'b00, 2'b00, v, d);
    serve(0, -1, -1, 2'b00, 2'b11, v, d);
    nv = 0;
    for (int k = 0; k < GAP + 10; k++) begin
      #1;
      if (m_tx_vld === 1'b1) nv++;
      step();
    end
    n_checks++;
    if (nv != 0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL alt_idle: extra vld=%0d pending=%0d, expected 0 and 0", nv, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int v, d;
    r0_count = 11'd40;
    r0_req = 1'b1;
    sb.push_back('{1'b0, 11'd40});
    serve(0, 30, -1, 2'b00, 2'b01, v, d);
    r0_count = 11'd12;
    r1_count = 11'd4;
    r0_req = 1'b1;
    r1_req = 1'b1;
    sb.push_back('{1'b0, 11'd12});
    sb.push_back('{1'b1, 11'd4});
    serve(0, -1, -1, 2'b00, 2'b01, v, d);
    serve(0, -1, -1, 2'b00, 2'b10, v, d);
  endtask

  initial begin
    reset = 1'b1;
    r0_req = 1'b0;
    r1_req = 1'b0;
    r0_count = '0;
    r1_count = '0;
    m_tx_busy = 1'b0;
    m_tx_adv = 1'b0;
    m_tx_last = 1'b0;
    m_tx_addr = '0;
    step();
    test_reset();
    test_both();
    test_single();
    test_timeout();
    test_alternate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 24, meaning idle cycles enforced after each frame before next grant.
REQ-002 SHALL have parameter START_TIMEOUT, default 255, meaning max cycles from m_tx_vld pulse to m_tx_busy rise.
REQ-003 SHALL have port clk  in  1  sole clock, all logic posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports r0_req / r1_req  in  1 each  level frame request, held until grant.
REQ-006 SHALL have ports r0_count / r1_count  in  11 each  frame byte count, stable while req high.
REQ-007 SHALL have ports r0_data / r1_data  in  8 each  byte at tx_addr from requester buffer.
REQ-008 SHALL have ports r0_gnt / r1_gnt  out  1 each  one-cycle pulse, request accepted.
REQ-009 SHALL have ports r0_done / r1_done  out  1 each  one-cycle pulse, frame finished or aborted.
REQ-010 SHALL have ports r0_adv / r1_adv  out  1 each  m_tx_adv gated to the owner.
REQ-011 SHALL have port tx_addr  out  11  m_tx_addr fanned out to both requesters.
REQ-012 SHALL have ports m_tx_vld out 1, m_tx_count out 11, m_tx_data out 8  MAC start, length, byte.
REQ-013 SHALL have ports m_tx_busy, m_tx_adv, m_tx_last in 1 each, m_tx_addr in 11  MAC status/byte strobes.
REQ-014 SHALL have port timeout_err  out  1  one-cycle pulse when a start times out.

Function
REQ-015 SHALL implement states IDLE, START, WAIT_BUSY, SEND, GAP.
REQ-016 IDLE: when any req high and m_tx_busy low, SHALL pick owner round-robin (last-served loses ties; after reset r0 wins), pulse rN_gnt, latch owner and rN_count, go START.
REQ-017 START: SHALL pulse m_tx_vld for exactly one cycle with m_tx_count = latched count, go WAIT_BUSY.
REQ-018 WAIT_BUSY: on m_tx_busy high go SEND; after START_TIMEOUT cycles without it SHALL pulse timeout_err and owner done, go GAP.
REQ-019 SEND: SHALL go GAP on cycle where m_tx_adv & m_tx_last, or when m_tx_busy falls, whichever first; owner done pulses that same cycle's next cycle (1-cycle latency).
REQ-020 GAP: SHALL count GAP_CYCLES cycles then return IDLE; GAP_CYCLES = 0 returns IDLE next cycle.
REQ-021 m_tx_data SHALL be combinational mux of owner's rN_data; tx_addr SHALL equal m_tx_addr combinationally.
REQ-022 rN_adv SHALL equal m_tx_adv only for owner in SEND; non-owner adv SHALL stay 0.
REQ-023 Requester dropping req after grant SHALL NOT affect the frame in progress.
REQ-024 Both req high in IDLE same cycle: exactly one gnt; other served next IDLE.
REQ-025 m_tx_count latched value SHALL be 11 bits unmodified; count 0 forwarded as-is.
REQ-026 Timeout counter SHALL saturate, never wrap; gap counter width = clog2(GAP_CYCLES+1).

Reset
REQ-027 reset high SHALL asynchronously force IDLE, last-served = r1 (so r0 wins first), all counters 0.
REQ-028 During and after reset all pulse outputs (gnt, done, adv, m_tx_vld, timeout_err) SHALL be 0; m_tx_count 0.
REQ-029 Reset mid-frame SHALL not emit done; requesters re-request after reset.

Structure
REQ-030 State enum and ETH_LEN_W = 11 SHALL live in shared package eth_pkg.
REQ-031 Single module; round-robin picker inline, no sub-module.

Verification
REQ-032 r0_req, count 60; MAC model busy 2 cycles after vld, 60 adv, last on 60th -> one r0_gnt, one m_tx_vld with count 60, 60 r0_adv, r0_done once, 0 r1_adv.
REQ-033 r0_req and r1_req same cycle after reset -> r0 served first, r1 gnt exactly GAP_CYCLES+1 cycles after r0 frame end.
REQ-034 MAC never raises busy -> timeout_err and r1_done at START_TIMEOUT+1 cycles after m_tx_vld, then GAP, then IDLE.
REQ-035 r1 continuously requesting, r0 requests mid-r1 frame -> r0 granted next, alternating thereafter.
REQ-036 reset asserted during SEND byte 30 -> all outputs 0 immediately, no done; after release r0 request granted normally.
REQ-037 m_tx_addr sweep 0..59 with r0_data = addr -> m_tx_data equals addr each cycle, same cycle.
